// File: rtl/tx_data_ascii_formatter_pkg.sv
// Shared definitions for the Tx_Data ASCII formatter: FSM state encoding,
// ASCII byte constants and a digit-count helper for elaboration checks.
package tx_data_ascii_formatter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    // Decimal digits needed for 2^width-1, i.e. floor(width*log10(2))+1.
    function automatic int unsigned min_digits(input int unsigned width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/tx_data_ascii_formatter_dd.sv
// Sequential double-dabble binary-to-BCD converter. A start pulse loads the
// binary value; done pulses for one cycle when bcd_out holds the result,
// which then stays stable until the next start.
module bcd_double_dabble #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin_in,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_adj;
    logic [DATA_W-1:0] bin;
    logic [CNT_W-1:0]  remaining;
    logic              done_q;

    // Add-3 correction on every nibble that is 5 or more.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift register: load on start, then one adjust+shift per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd       <= '0;
            bin       <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                // The first shift is folded into the load: an all-zero BCD
                // never needs correction, so total shifts stay DATA_W.
                {bcd, bin} <= {{BCD_W{1'b0}}, bin_in} << 1;
                remaining  <= CNT_W'(DATA_W - 1);
                done_q     <= (DATA_W == 1);
            end else if (remaining != '0) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                remaining  <= remaining - 1'b1;
                done_q     <= (remaining == CNT_W'(1));
            end
        end
    end

    assign done    = done_q;
    assign bcd_out = bcd;

endmodule

// File: rtl/tx_data_ascii_formatter.sv
// Tx_Data to decimal ASCII line formatter feeding the UART transmitter.
// Accepts one word in IDLE, converts it with double-dabble, then streams
// digit bytes plus CR/LF over a valid/ready byte interface.
// Optional build macro SIGNED_FMT_EN: treat the input as two's complement
// and prefix a '+'/'-' sign byte.
module tx_data_ascii_formatter
    import tx_data_ascii_formatter_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DIGITS = 4,
    parameter int unsigned EOL_CR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Tx_Data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy
);

`ifdef SIGNED_FMT_EN
    localparam int unsigned SIGN_BYTES = 1;
`else
    localparam int unsigned SIGN_BYTES = 0;
`endif
    localparam int unsigned LINE_LEN = SIGN_BYTES + DIGITS + ((EOL_CR != 0) ? 1 : 0) + 1;
    localparam int unsigned IDX_W    = $clog2(LINE_LEN);

    if (DIGITS < min_digits(DATA_W)) begin : g_digits_check
        $error("DIGITS is too small to represent 2^DATA_W-1");
    end

    if (DATA_W < 16) begin : g_upper_unused
        logic unused_upper;
        assign unused_upper = ^Tx_Data[15:DATA_W];
    end

    state_t                state, state_n;
    logic [IDX_W-1:0]      idx, idx_n, sel_idx;
    logic [7:0]            byte_q, byte_n, sel_byte;
    logic                  valid_q, valid_n;
    logic                  accept;
    logic [DATA_W-1:0]     mag;
    logic                  dd_done;
    logic [4*DIGITS-1:0]   dd_bcd;

`ifdef SIGNED_FMT_EN
    logic neg, in_neg;

    assign in_neg = Tx_Data[DATA_W-1];
    assign mag    = in_neg ? (~Tx_Data[DATA_W-1:0] + 1'b1) : Tx_Data[DATA_W-1:0];

    // Sign of the accepted word, held for the whole line.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= in_neg;
        end
    end
`else
    assign mag = Tx_Data[DATA_W-1:0];
`endif

    bcd_double_dabble #(
        .DATA_W(DATA_W),
        .DIGITS(DIGITS)
    ) u_dd (
        .clk    (clk),
        .reset  (reset),
        .start  (accept),
        .bin_in (mag),
        .done   (dd_done),
        .bcd_out(dd_bcd)
    );

    // Index of the byte to load next: first byte on entry to EMIT, else idx+1.
    assign sel_idx = (state == EMIT) ? idx + 1'b1 : '0;

    // Line layout: [sign] digits (MSD first) [CR] LF.
    always_comb begin
        sel_byte = ASCII_LF;
`ifdef SIGNED_FMT_EN
        if (32'(sel_idx) == 0) begin
            sel_byte = neg ? ASCII_MINUS : ASCII_PLUS;
        end
`endif
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (32'(sel_idx) == SIGN_BYTES + k) begin
                sel_byte = ASCII_ZERO + {4'h0, dd_bcd[4*(DIGITS-1-k) +: 4]};
            end
        end
        if (EOL_CR != 0 && 32'(sel_idx) == SIGN_BYTES + DIGITS) begin
            sel_byte = ASCII_CR;
        end
    end

    // Next-state, byte sequencing and handshake decisions.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        byte_n  = byte_q;
        valid_n = valid_q;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (data_valid) begin
                    accept  = 1'b1;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                if (dd_done) begin
                    state_n = EMIT;
                    idx_n   = '0;
                    byte_n  = sel_byte;
                    valid_n = 1'b1;
                end
            end
            EMIT: begin
                if (byte_ready) begin
                    if (32'(idx) == LINE_LEN - 1) begin
                        state_n = IDLE;
                        idx_n   = '0;
                        byte_n  = '0;
                        valid_n = 1'b0;
                    end else begin
                        idx_n  = idx + 1'b1;
                        byte_n = sel_byte;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, byte index and registered byte outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            byte_q  <= byte_n;
            valid_q <= valid_n;
        end
    end

    assign data_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign byte_out   = byte_q;
    assign byte_valid = valid_q;

endmodule

// File: doc/tx_data_ascii_formatter.md
Name: tx_data_ascii_formatter

Overview:
Sits directly downstream of the axis re-ordering stage. It takes the 16-bit Tx_Data word, which carries a 10-bit axis value in bits [9:0] and zeros above, and converts it to fixed-width decimal ASCII with a sequential double-dabble algorithm. It then streams the characters, followed by an end-of-line sequence, one byte at a time to the UART transmitter using a valid/ready handshake.

Parameters:
DATA_W, 10, number of significant input bits taken from Tx_Data[DATA_W-1:0].
DIGITS, 4, number of decimal digits emitted. Must be ≥ digits of 2^DATA_W-1; checked by an elaboration-time assertion.
EOL_CR, 1, 1 = emit CR (0x0D) before LF (0x0A); 0 = emit LF only.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
Tx_Data  in  16  formatted axis word from the upstream stage.
data_valid  in  1  Tx_Data is valid this cycle.
data_ready  out  1  block can accept a word (high only in IDLE).
byte_out  out  8  ASCII character to the UART transmitter.
byte_valid  out  1  byte_out is valid.
byte_ready  in  1  UART transmitter accepts byte_out this cycle.
busy  out  1  high in CONVERT or EMIT.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high. On reset: state=IDLE, data_ready=1, byte_valid=0, byte_out=8'h00, busy=0, all internal registers cleared.
- IDLE:
  - data_ready=1.
  - Accept when data_valid && data_ready. Latch Tx_Data[DATA_W-1:0]; bits [15:DATA_W] are ignored.
  - Go to CONVERT next cycle.
- CONVERT:
  - Runs exactly DATA_W cycles.
  - Each cycle: every BCD nibble ≥5 gets +3, then the {bcd, bin} register shifts left 1.
  - BCD register width is 4*DIGITS.
  - After the DATA_W-th shift, go to EMIT.
- EMIT:
  - Byte sequence, MSD first: DIGITS digit bytes, each 0x30 + digit (leading zeros are sent); then 0x0D if EOL_CR; then 0x0A.
  - byte_valid=1 throughout EMIT.
  - byte_out and byte_valid are registered and stay stable while byte_ready=0.
  - The byte index advances only on byte_valid && byte_ready.
  - The handshake on the final byte returns to IDLE: byte_valid=0 and data_ready=1 on the next cycle.
- Latency: acceptance in cycle N → first byte_valid in cycle N+1+DATA_W (cycle 11 for the default).
- Throughput: the next word can be accepted the cycle after the final byte handshake. No back-to-back overlap.
- Words presented while data_ready=0 are not consumed. The upstream must hold them; this block does no buffering.
- byte_ready asserted outside EMIT has no effect.
- Reset during CONVERT or EMIT aborts immediately. No partial line is completed and no further bytes are emitted.
- Simultaneous reset and data_valid: reset wins and the word is not accepted.

Optional Feature:
SIGNED_FMT_EN:
- When defined:
  - Tx_Data[DATA_W-1:0] is two's complement.
  - A sign byte is emitted before the digits: '-' (0x2D) if negative, '+' (0x2B) otherwise.
  - The magnitude (−2^(DATA_W-1) gives 2^(DATA_W-1)) is computed in the accept cycle and fed to double-dabble. CONVERT length is unchanged.
  - Line length = DIGITS + 1 + EOL bytes.
- When undefined: the input is unsigned (0..2^DATA_W-1) and no sign byte is sent.

Decomposition:
- Shared package:
  - state enum {IDLE, CONVERT, EMIT};
  - ASCII constants ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_PLUS=8'h2B, ASCII_MINUS=8'h2D;
  - function computing the minimum digit count for a bit width.
- Sub-module bcd_double_dabble:
  - Parameterised by DATA_W and DIGITS.
  - Ports: start, bin_in, done, bcd_out.
  - Multi-cycle, owns the shift register.
- The top level owns the FSM, byte sequencing, handshake and the sign logic.

Test Plan:
1. Tx_Data=16'h03FF, byte_ready=1 → bytes 31 30 32 33 0D 0A; first byte_valid 11 cycles after acceptance; data_ready returns to 1 after the 0A handshake.
2. Tx_Data=16'h0000 → 30 30 30 30 0D 0A; Tx_Data=16'hFC07 → 30 30 30 37 0D 0A (upper bits ignored).
3. Back-pressure on 16'h0040: hold byte_ready=0 for 5 cycles at byte index 2 → byte_out stays 0x36 with byte_valid=1; data_ready=0 and a new data_valid is ignored; the sequence resumes with 0x34 0x0D 0x0A.
4. Reset asserted after 2 bytes of 16'h0123 → next cycle byte_valid=0, byte_out=00, data_ready=1; then 16'h0064 → 30 31 30 30 0D 0A.
5. EOL_CR=0 with 16'h0009 → 30 30 30 39 0A only; busy deasserts after 0A.
6. SIGNED_FMT_EN defined: 16'h0200 → 2D 30 35 31 32 0D 0A; 16'h01FF → 2B 30 35 31 31 0D 0A; 16'h03FF → 2D 30 30 30 31 0D 0A.
